// File: rtl/single_port_ram_loader.sv
// Sequential loader that fills a small RAM from the top index downward and
// exposes it for combinational readback in load order.
module single_port_ram_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_q,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   wr_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      mask;
    logic                  xfer;
    logic                  last;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;

    assign in_ready = (state == ST_LOAD);
    assign busy     = (state == ST_LOAD);
    assign done     = (state == ST_DONE);
    assign xfer     = in_valid && in_ready;

    // DEPTH-1-x in ADDR_WIDTH bits is the bitwise inverse of x.
    assign wr_idx = ~wr_count[ADDR_WIDTH-1:0];
    assign rd_idx = ~rd_addr;
    assign last   = (wr_count[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});

    assign rd_q = mask[rd_idx] ? mem[rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wr_count <= '0;
            mask     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        wr_count <= '0;
                        mask     <= '0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        mask[wr_idx] <= 1'b1;
                        wr_count     <= wr_count + 1'b1;
                        if (last) state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage is not reset; the mask alone decides what readback exposes.
    always_ff @(posedge clk) begin
        if (xfer && !reset) mem[wr_idx] <= in_data;
    end

endmodule

// File: tb/tb_single_port_ram_loader.sv
// Randomized and directed bench for single_port_ram_loader with a queue-based
// scoreboard fed by a load-order reference model.
`timescale 1ns/1ps
module tb_single_port_ram_loader;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_q;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;

    single_port_ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .rd_addr(rd_addr),
        .rd_q(rd_q), .busy(busy), .done(done), .wr_count(wr_count)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic                       rdy;
        logic                       bsy;
        logic                       dn;
        logic [AW:0]                cnt;
        logic [DEPTH-1:0][DW-1:0]   rd;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: words accepted in the current load, in arrival order.
    int            mode = 0;   // 0 idle, 1 loading, 2 finished
    logic [DW-1:0] words[$];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic v, input logic [DW-1:0] d);
        exp_t e;
        if (r) begin
            mode = 0;
            words.delete();
        end else if (mode == 1) begin
            if (v) begin
                words.push_back(d);
                if (words.size() == DEPTH) mode = 2;
            end
        end else if (s) begin
            mode = 1;
            words.delete();
        end
        e.rdy = (mode == 1);
        e.bsy = (mode == 1);
        e.dn  = (mode == 2);
        e.cnt = (AW+1)'(words.size());
        for (int a = 0; a < DEPTH; a++)
            e.rd[a] = (a < words.size()) ? words[a] : '0;
        sbq.push_back(e);
    endtask

    task automatic step(input logic r, input logic s, input logic v, input logic [DW-1:0] d);
        reset    = r;
        start    = s;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_edge(r, s, v, d);
        #1;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    // Monitor: after every edge, compare control outputs and sweep readback.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("in_ready", in_ready, e.rdy);
                chk("busy", busy, e.bsy);
                chk("done", done, e.dn);
                chk("wr_count", wr_count, e.cnt);
                for (int a = 0; a < DEPTH; a++) begin
                    rd_addr = AW'(a);
                    #1;
                    chk($sformatf("rd_q[%0d]", a), rd_q, e.rd[a]);
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] pat [8];
        pat = '{8'hAA, 8'hF0, 8'h0F, 8'hCC, 8'hE7, 8'h18, 8'hB7, 8'hED};

        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 8'h99);
        idle(1);

        // Full back-to-back load, then idle in finished state
        step(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, pat[i]);
        idle(2);

        // Restart from finished state with a single word
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 8'h55);
        idle(2);

        // Gapped transfers (new load started mid-LOAD is ignored, so reset first)
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 8'h11);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 8'h22);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 8'h33);
        idle(2);

        // start while loading is ignored; in_valid while finished is ignored
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'h40 + DW'(i));
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 8'h77);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'hA0 + DW'(i));
        step(1'b0, 1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b0, 1'b1, 8'h5B);
        idle(1);

        // Reset mid-load wins over start and transfer on the same edge
        step(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, pat[7-i]);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'hC0 + DW'(i));
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 8'h3C);
        idle(1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) != 0), DW'($urandom));
        idle(2);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
